// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a datapath's instruction-fetch and data ports onto
// one single-port RAM. Data accesses have fixed priority over fetches.
// Each access runs IDLE -> ACC -> HIT -> IDLE. RAM strobes, address and
// store data are driven only from registers latched when the access starts.
// Optional feature: define MEM_ARBITER_WATCHDOG_EN to add a watchdog. It ends
// an access that sees no ram_ready for WD_LIMIT cycles with load data
// 32'hBAD1BAD1 and sets a sticky mem_err.
module mem_arbiter #(
    parameter logic [7:0] WD_LIMIT = 8'd255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        mem_err
);

    typedef enum logic [2:0] {IDLE, DACC, IACC, DHIT, IHIT} state_t;

    localparam logic [31:0] WD_LOAD   = 32'hBAD1_BAD1;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      r_state;
    logic        r_ihit, r_dhit;
    logic        r_ramREN, r_ramWEN;
    logic [31:0] r_ramaddr, r_ramstore;
    logic [31:0] r_imemload, r_dmemload;
    logic        w_in_acc;
    logic        w_wd_fire;

    assign w_in_acc = (r_state == DACC) || (r_state == IACC);

`ifdef MEM_ARBITER_WATCHDOG_EN
    logic [7:0] r_wd_cnt;
    logic       r_mem_err;

    // The watchdog fires on the access cycle that would make the stall count reach WD_LIMIT.
    assign w_wd_fire = w_in_acc && !ram_ready && (r_wd_cnt == WD_LIMIT - 8'd1);

    // Count stalled access cycles; the count is zero whenever an access state is entered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wd_cnt <= 8'd0;
        end else if (w_in_acc && !ram_ready) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end else begin
            r_wd_cnt <= 8'd0;
        end
    end

    // Sticky error flag: once the watchdog fires, only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mem_err <= 1'b0;
        end else if (w_wd_fire) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_wd_fire = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Arbitration FSM; every output is registered and updated on state transitions.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state    <= IDLE;
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= 32'd0;
            r_ramstore <= 32'd0;
            r_imemload <= 32'd0;
            r_dmemload <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((dmemWEN || dmemREN) && !halt) begin
                        // A simultaneous read and write request is treated as a write.
                        r_state    <= DACC;
                        r_ramaddr  <= dmemaddr & WORD_MASK;
                        r_ramstore <= dmemstore;
                        r_ramWEN   <= dmemWEN;
                        r_ramREN   <= !dmemWEN;
                    end else if (imemREN && !halt) begin
                        r_state   <= IACC;
                        r_ramaddr <= imemaddr & WORD_MASK;
                        r_ramWEN  <= 1'b0;
                        r_ramREN  <= 1'b1;
                    end
                end
                DACC: begin
                    if (ram_ready || w_wd_fire) begin
                        r_state  <= DHIT;
                        r_dhit   <= 1'b1;
                        r_ramREN <= 1'b0;
                        r_ramWEN <= 1'b0;
                        if (!ram_ready) begin
                            r_dmemload <= WD_LOAD;
                        end else if (r_ramREN) begin
                            r_dmemload <= ramload;
                        end
                    end
                end
                IACC: begin
                    if (ram_ready || w_wd_fire) begin
                        r_state    <= IHIT;
                        r_ihit     <= 1'b1;
                        r_ramREN   <= 1'b0;
                        r_ramWEN   <= 1'b0;
                        r_imemload <= ram_ready ? ramload : WD_LOAD;
                    end
                end
                DHIT: begin
                    r_state <= IDLE;
                    r_dhit  <= 1'b0;
                end
                IHIT: begin
                    r_state <= IDLE;
                    r_ihit  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign ramREN   = r_ramREN;
    assign ramWEN   = r_ramWEN;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;
    assign imemload = r_imemload;
    assign dmemload = r_dmemload;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written multi-cycle sequences
// for mem_arbiter. Define MEM_ARBITER_WATCHDOG_EN to exercise the watchdog build.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN, halt, ram_ready;
    logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
    logic [31:0] imemload, dmemload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

`ifdef MEM_ARBITER_WATCHDOG_EN
    mem_arbiter #(.WD_LIMIT(8'd4)) dut (
`else
    mem_arbiter dut (
`endif
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
        .halt(halt), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
        .mem_err(mem_err)
    );

    typedef struct {
        logic        d_ren, d_wen, i_ren, hlt, rdy;
        logic [31:0] iaddr, daddr, dstore, rload;
        logic        e_ihit, e_dhit, e_ren, e_wen;
        logic [31:0] e_raddr, e_rstore, e_iload, e_dload;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic d_ren, d_wen, i_ren, hlt, rdy,
                       input logic [31:0] iaddr, daddr, dstore, rload,
                       input logic e_ihit, e_dhit, e_ren, e_wen,
                       input logic [31:0] e_raddr, e_rstore, e_iload, e_dload);
        vec_t v;
        v.d_ren = d_ren; v.d_wen = d_wen; v.i_ren = i_ren; v.hlt = hlt; v.rdy = rdy;
        v.iaddr = iaddr; v.daddr = daddr; v.dstore = dstore; v.rload = rload;
        v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_raddr = e_raddr; v.e_rstore = e_rstore; v.e_iload = e_iload; v.e_dload = e_dload;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic d_ren, d_wen, i_ren, hlt, rdy,
                         input logic [31:0] iaddr, daddr, dstore, rload);
        dmemREN = d_ren; dmemWEN = d_wen; imemREN = i_ren; halt = hlt; ram_ready = rdy;
        imemaddr = iaddr; dmemaddr = daddr; dmemstore = dstore; ramload = rload;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ihit"},     {31'd0, ihit},    32'd0);
        check({tag, ".dhit"},     {31'd0, dhit},    32'd0);
        check({tag, ".ramREN"},   {31'd0, ramREN},  32'd0);
        check({tag, ".ramWEN"},   {31'd0, ramWEN},  32'd0);
        check({tag, ".ramaddr"},  ramaddr,          32'd0);
        check({tag, ".ramstore"}, ramstore,         32'd0);
        check({tag, ".imemload"}, imemload,         32'd0);
        check({tag, ".dmemload"}, dmemload,         32'd0);
        check({tag, ".mem_err"},  {31'd0, mem_err}, 32'd0);
    endtask

    initial begin
        // Row inputs are presented for one cycle; expected values are the outputs after the following edge.
        //   dR dW iR ht rdy iaddr  daddr  dstore        rload         | ih dh rR rW raddr  rstore        iload         dload
        add(0, 0, 1, 0, 1, 32'h44, 32'h0,   32'h0,        32'h8C220004,  0, 0, 1, 0, 32'h44,  32'h0,        32'h0,        32'h0);
        add(0, 0, 1, 0, 1, 32'h44, 32'h0,   32'h0,        32'h8C220004,  1, 0, 0, 0, 32'h44,  32'h0,        32'h8C220004, 32'h0);
        add(0, 0, 0, 0, 1, 32'h44, 32'h0,   32'h0,        32'h8C220004,  0, 0, 0, 0, 32'h44,  32'h0,        32'h8C220004, 32'h0);
        add(1, 0, 1, 0, 1, 32'h44, 32'h80,  32'h0,        32'h11112222,  0, 0, 1, 0, 32'h80,  32'h0,        32'h8C220004, 32'h0);
        add(1, 0, 1, 0, 1, 32'h44, 32'h80,  32'h0,        32'h11112222,  0, 1, 0, 0, 32'h80,  32'h0,        32'h8C220004, 32'h11112222);
        add(0, 0, 1, 0, 1, 32'h44, 32'h80,  32'h0,        32'h33334444,  0, 0, 0, 0, 32'h80,  32'h0,        32'h8C220004, 32'h11112222);
        add(0, 0, 1, 0, 1, 32'h44, 32'h80,  32'h0,        32'h33334444,  0, 0, 1, 0, 32'h44,  32'h0,        32'h8C220004, 32'h11112222);
        add(0, 0, 1, 0, 1, 32'h44, 32'h80,  32'h0,        32'h33334444,  1, 0, 0, 0, 32'h44,  32'h0,        32'h33334444, 32'h11112222);
        add(0, 1, 0, 0, 0, 32'h44, 32'h103, 32'hDEADBEEF, 32'h0,         0, 0, 0, 0, 32'h44,  32'h0,        32'h33334444, 32'h11112222);
        add(0, 1, 0, 0, 0, 32'h44, 32'h103, 32'hDEADBEEF, 32'h0,         0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
        add(0, 1, 0, 0, 0, 32'h44, 32'h200, 32'hDEADBEEF, 32'h0,         0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
        add(0, 1, 0, 0, 1, 32'h44, 32'h200, 32'h12345678, 32'h55555555,  0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
        add(0, 0, 0, 0, 1, 32'h44, 32'h200, 32'h12345678, 32'h55555555,  0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h33334444, 32'h11112222);
        add(1, 1, 0, 0, 1, 32'h44, 32'h8,   32'hA5A5A5A5, 32'h66666666,  0, 0, 0, 1, 32'h8,   32'hA5A5A5A5, 32'h33334444, 32'h11112222);
        add(1, 1, 0, 0, 1, 32'h44, 32'h8,   32'hA5A5A5A5, 32'h66666666,  0, 1, 0, 0, 32'h8,   32'hA5A5A5A5, 32'h33334444, 32'h11112222);
        add(1, 0, 1, 1, 1, 32'h44, 32'h8,   32'hA5A5A5A5, 32'h66666666,  0, 0, 0, 0, 32'h8,   32'hA5A5A5A5, 32'h33334444, 32'h11112222);
        add(0, 0, 1, 0, 0, 32'h60, 32'h8,   32'hA5A5A5A5, 32'h66666666,  0, 0, 1, 0, 32'h60,  32'hA5A5A5A5, 32'h33334444, 32'h11112222);
        add(0, 0, 1, 1, 0, 32'h60, 32'h8,   32'hA5A5A5A5, 32'h66666666,  0, 0, 1, 0, 32'h60,  32'hA5A5A5A5, 32'h33334444, 32'h11112222);
        add(0, 0, 1, 1, 1, 32'h60, 32'h8,   32'hA5A5A5A5, 32'h77777777,  1, 0, 0, 0, 32'h60,  32'hA5A5A5A5, 32'h77777777, 32'h11112222);
        add(0, 0, 1, 1, 1, 32'h60, 32'h8,   32'hA5A5A5A5, 32'h77777777,  0, 0, 0, 0, 32'h60,  32'hA5A5A5A5, 32'h77777777, 32'h11112222);

        // Reset state
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        nRST = 1'b0;
        repeat (2) step();
        check_all_zero("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].d_ren, vecs[i].d_wen, vecs[i].i_ren, vecs[i].hlt, vecs[i].rdy,
                  vecs[i].iaddr, vecs[i].daddr, vecs[i].dstore, vecs[i].rload);
            step();
            check({tag, ".ihit"},     {31'd0, ihit},   {31'd0, vecs[i].e_ihit});
            check({tag, ".dhit"},     {31'd0, dhit},   {31'd0, vecs[i].e_dhit});
            check({tag, ".ramREN"},   {31'd0, ramREN}, {31'd0, vecs[i].e_ren});
            check({tag, ".ramWEN"},   {31'd0, ramWEN}, {31'd0, vecs[i].e_wen});
            check({tag, ".ramaddr"},  ramaddr,         vecs[i].e_raddr);
            check({tag, ".ramstore"}, ramstore,        vecs[i].e_rstore);
            check({tag, ".imemload"}, imemload,        vecs[i].e_iload);
            check({tag, ".dmemload"}, dmemload,        vecs[i].e_dload);
        end

        // Halt held with pending requests: no access for 10 cycles
        drive(1, 0, 1, 1, 1, 32'h60, 32'h8, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("halt%0d.ramREN", i), {31'd0, ramREN}, 32'd0);
            check($sformatf("halt%0d.ihit", i),   {31'd0, ihit},   32'd0);
        end

        // Reset in the middle of a stalled write
        drive(0, 1, 0, 0, 0, 32'h0, 32'h10, 32'hCAFEF00D, 32'h0);
        step();
        check("midrst.pre.ramWEN",   {31'd0, ramWEN}, 32'd1);
        check("midrst.pre.ramaddr",  ramaddr,         32'h10);
        #2;
        nRST = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        nRST = 1'b1;
        step();
        check("midrst.post.ramWEN", {31'd0, ramWEN}, 32'd0);
        check("midrst.post.ramREN", {31'd0, ramREN}, 32'd0);

`ifdef MEM_ARBITER_WATCHDOG_EN
        // Watchdog: four stalled fetch cycles end the access with the error pattern
        drive(0, 0, 1, 0, 0, 32'h70, 32'h0, 32'h0, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("wd%0d.ramREN", i), {31'd0, ramREN}, 32'd1);
            check($sformatf("wd%0d.ihit", i),   {31'd0, ihit},   32'd0);
        end
        step();
        check("wd.ihit",     {31'd0, ihit},    32'd1);
        check("wd.imemload", imemload,         32'hBAD1BAD1);
        check("wd.mem_err",  {31'd0, mem_err}, 32'd1);
        drive(0, 0, 0, 0, 1, 32'h70, 32'h0, 32'h0, 32'h0);
        repeat (3) step();
        check("wd.sticky",   {31'd0, mem_err}, 32'd1);
        check("wd.ihit_off", {31'd0, ihit},    32'd0);
        nRST = 1'b0;
        #1;
        check("wd.rst_mem_err", {31'd0, mem_err}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
`else
        // No watchdog: a stalled fetch waits indefinitely, then completes on ram_ready
        drive(0, 0, 1, 0, 0, 32'h70, 32'h0, 32'h0, 32'h0);
        repeat (300) step();
        check("wait.ramREN",  {31'd0, ramREN},  32'd1);
        check("wait.ihit",    {31'd0, ihit},    32'd0);
        check("wait.mem_err", {31'd0, mem_err}, 32'd0);
        drive(0, 0, 1, 0, 1, 32'h70, 32'h0, 32'h0, 32'h0BADF00D);
        step();
        check("wait.done.ihit",     {31'd0, ihit}, 32'd1);
        check("wait.done.imemload", imemload,      32'h0BADF00D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WD_LIMIT, 255, number of access-state cycles allowed without ram_ready before the watchdog fires; 8-bit counter.
REQ-002 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-003 nRST  in  1  reset, asynchronous and active-low.
REQ-004 imemREN  in  1  instruction fetch request from datapath, held until ihit.
REQ-005 imemaddr  in  32  fetch byte address.
REQ-006 imemload  out  32  fetched instruction, valid while ihit=1.
REQ-007 ihit  out  1  fetch complete strobe.
REQ-008 dmemREN  in  1  data read request, held until dhit.
REQ-009 dmemWEN  in  1  data write request, held until dhit.
REQ-010 dmemaddr  in  32  data byte address.
REQ-011 dmemstore  in  32  write data.
REQ-012 dmemload  out  32  read data, valid while dhit=1.
REQ-013 dhit  out  1  data access complete strobe.
REQ-014 halt  in  1  datapath halted; blocks new accesses.
REQ-015 ramREN / ramWEN  out  1 each  single-port RAM read/write strobes.
REQ-016 ramaddr  out  32  RAM word address; bits [1:0] forced 0.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data, valid when ram_ready=1.
REQ-019 ram_ready  in  1  RAM access done, sampled only in an access state.
REQ-020 mem_err  out  1  sticky watchdog error flag.

Function
REQ-021 FSM states: IDLE, DACC, IACC, DHIT, IHIT.
REQ-022 IDLE: dmemWEN|dmemREN and halt=0 -> DACC; else imemREN and halt=0 -> IACC; else stay. Data has fixed priority over fetch.
REQ-023 Entering DACC/IACC latches address, write data and access type; RAM outputs come only from latched registers, so requestor input changes mid-access are ignored.
REQ-024 dmemWEN=1 and dmemREN=1 together: treated as a write; ramREN=0.
REQ-025 DACC/IACC: exactly one of ramREN/ramWEN high every cycle; ram_ready=1 -> DHIT/IHIT next cycle, ramload captured into the load register on that edge.
REQ-026 DHIT/IHIT: respective hit=1 for exactly one cycle, load output holds captured data, RAM strobes 0; next state IDLE unconditionally.
REQ-027 Write completion: dhit pulses; dmemload holds its previous value.
REQ-028 Minimum latency: request in IDLE with ram_ready tied 1 -> hit 2 cycles after request sampled; back-to-back accesses every 3 cycles.
REQ-029 ihit and dhit are never high in the same cycle.
REQ-030 halt rising during DACC/IACC: access completes normally; no new access starts while halt=1.
REQ-031 imemload/dmemload keep their last captured value outside hit cycles.

Reset
REQ-032 nRST=0 asynchronously forces IDLE, ihit=dhit=0, ramREN=ramWEN=0, ramaddr=ramstore=0, imemload=dmemload=0, mem_err=0, watchdog counter=0, including mid-access; the pending access is dropped.

Configuration
REQ-033 Macro MEM_ARBITER_WATCHDOG_EN defined: counter increments each DACC/IACC cycle without ram_ready, clears on state entry; reaching WD_LIMIT -> DHIT/IHIT with load data 32'hBAD1BAD1, mem_err set until reset.
REQ-034 Macro undefined: no counter; access states wait indefinitely for ram_ready; mem_err tied 0.

Verification
REQ-035 Reset mid-DACC with ramWEN=1 -> same cycle ramWEN=0, state IDLE, all outputs 0.
REQ-036 imemREN=1, imemaddr=0x00000044, ram_ready at 1st IACC cycle, ramload=0x8C220004 -> ramaddr=0x44, ramREN=1, ihit=1 with imemload=0x8C220004 exactly 2 cycles after request.
REQ-037 dmemREN=1 and imemREN=1 together, dmemaddr=0x80 -> data served first (dhit), then fetch (ihit) 3 cycles later; hits never overlap.
REQ-038 dmemWEN=1, dmemaddr=0x103, dmemstore=0xDEADBEEF, dmemaddr changed to 0x200 during DACC -> ramaddr=0x100, ramstore=0xDEADBEEF throughout, dhit one cycle.
REQ-039 halt=1 with imemREN=1 -> state stays IDLE, ramREN=0 for 10 cycles.
REQ-040 MEM_ARBITER_WATCHDOG_EN, WD_LIMIT=4, ram_ready=0 -> after 4 IACC cycles ihit=1, imemload=0xBAD1BAD1, mem_err=1 until reset.
